// File: rtl/uart_aes_framer.sv
// UART command framer for an AES core.
// Collects 16-byte key or plaintext payloads behind a one-byte command,
// hands plaintext to the core, and serialises the 16-byte ciphertext (or a
// one-byte key acknowledge) back to the UART transmitter with a short gap
// between bytes.
module uart_aes_framer #(
    parameter logic [7:0]  CMD_KEY        = 8'h4B,
    parameter logic [7:0]  CMD_ENC        = 8'h45,
    parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx_ready,
    input  logic [7:0]   rx_data,
    input  logic         tx_ready,
    output logic [7:0]   tx_data,
    output logic         tx_enable,
    output logic [127:0] key_out,
    output logic         key_valid,
    output logic [127:0] pt_out,
    output logic         pt_valid,
    input  logic         pt_accept,
    input  logic [127:0] ct_in,
    input  logic         ct_valid,
    output logic         busy,
    output logic         err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // Value of the idle counter on the last tolerated idle cycle.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RX_KEY,
        RX_PT,
        WAIT_CORE,
        WAIT_CT,
        TX_SEND,
        TX_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [119:0]   shift_q, shift_d;      // first 15 payload bytes; the 16th completes the word
    logic [3:0]     cnt_q, cnt_d;          // payload byte counter
    logic [TW-1:0]  tmo_q, tmo_d;          // idle cycles since last payload byte
    logic [127:0]   key_q, key_d;
    logic           key_valid_q, key_valid_d;
    logic [127:0]   pt_q, pt_d;
    logic           pt_valid_q, pt_valid_d;
    logic [127:0]   tx_buf_q, tx_buf_d;    // outgoing bytes, next one in [127:120]
    logic [4:0]     tx_left_q, tx_left_d;  // bytes still to send
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_enable_q, tx_enable_d;
    logic           gap_q, gap_d;          // second cycle of the inter-byte gap
    logic           err_q, err_d;
    logic [127:0]   rx_word;

    // Payload word as it looks once the current byte is appended.
    assign rx_word = {shift_q, rx_data};

    // Next-state logic for the framer FSM and all its datapath registers.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        pt_d        = pt_q;
        pt_valid_d  = pt_valid_q;
        tx_buf_d    = tx_buf_q;
        tx_left_d   = tx_left_q;
        tx_data_d   = tx_data_q;
        tx_enable_d = 1'b0;
        gap_d       = gap_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (rx_ready) begin
                    if (rx_data == CMD_KEY || rx_data == CMD_ENC) begin
                        state_d = (rx_data == CMD_KEY) ? RX_KEY : RX_PT;
                        err_d   = 1'b0;
                        cnt_d   = 4'd0;
                        tmo_d   = '0;
                        shift_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            RX_KEY, RX_PT: begin
                // A byte always wins over a coincident timeout.
                if (rx_ready) begin
                    shift_d = rx_word[119:0];
                    cnt_d   = cnt_q + 4'd1;
                    tmo_d   = '0;
                    if (cnt_q == 4'd15) begin
                        if (state_q == RX_KEY) begin
                            key_d       = rx_word;
                            key_valid_d = 1'b1;
                            tx_buf_d    = {CMD_KEY, 120'd0};
                            tx_left_d   = 5'd1;
                            state_d     = TX_SEND;
                        end else begin
                            pt_d       = rx_word;
                            pt_valid_d = 1'b1;
                            state_d    = WAIT_CORE;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    shift_d = '0;
                    cnt_d   = 4'd0;
                    tmo_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            WAIT_CORE: begin
                if (rx_ready) begin
                    err_d = 1'b1;
                end
                if (pt_valid_q && pt_accept) begin
                    pt_valid_d = 1'b0;
                    state_d    = WAIT_CT;
                end
            end

            WAIT_CT: begin
                if (rx_ready) begin
                    err_d = 1'b1;
                end
                if (ct_valid) begin
                    tx_buf_d  = ct_in;
                    tx_left_d = 5'd16;
                    state_d   = TX_SEND;
                end
            end

            TX_SEND: begin
                if (rx_ready) begin
                    err_d = 1'b1;
                end
                if (tx_ready) begin
                    tx_enable_d = 1'b1;
                    tx_data_d   = tx_buf_q[127:120];
                    tx_buf_d    = {tx_buf_q[119:0], 8'h00};
                    tx_left_d   = tx_left_q - 5'd1;
                    gap_d       = 1'b0;
                    state_d     = TX_GAP;
                end
            end

            TX_GAP: begin
                // Two blind cycles give the UART time to drop tx_ready.
                if (rx_ready) begin
                    err_d = 1'b1;
                end
                if (gap_q) begin
                    state_d = (tx_left_q != 5'd0) ? TX_SEND : IDLE;
                end else begin
                    gap_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= 4'd0;
            tmo_q       <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            pt_q        <= '0;
            pt_valid_q  <= 1'b0;
            tx_buf_q    <= '0;
            tx_left_q   <= 5'd0;
            tx_data_q   <= 8'h00;
            tx_enable_q <= 1'b0;
            gap_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            pt_q        <= pt_d;
            pt_valid_q  <= pt_valid_d;
            tx_buf_q    <= tx_buf_d;
            tx_left_q   <= tx_left_d;
            tx_data_q   <= tx_data_d;
            tx_enable_q <= tx_enable_d;
            gap_q       <= gap_d;
            err_q       <= err_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_enable = tx_enable_q;
    assign key_out   = key_q;
    assign key_valid = key_valid_q;
    assign pt_out    = pt_q;
    assign pt_valid  = pt_valid_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_uart_aes_framer.sv
// Directed bench for uart_aes_framer: key load, encrypt handshake,
// ciphertext serialisation, timeout, protocol errors and mid-load reset.
module tb_uart_aes_framer;

    localparam int TMO = 40;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx_ready = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         tx_ready = 1'b1;
    logic [7:0]   tx_data;
    logic         tx_enable;
    logic [127:0] key_out;
    logic         key_valid;
    logic [127:0] pt_out;
    logic         pt_valid;
    logic         pt_accept = 1'b0;
    logic [127:0] ct_in = '0;
    logic         ct_valid = 1'b0;
    logic         busy;
    logic         err;

    uart_aes_framer #(
        .CMD_KEY        (8'h4B),
        .CMD_ENC        (8'h45),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_enable (tx_enable),
        .key_out   (key_out),
        .key_valid (key_valid),
        .pt_out    (pt_out),
        .pt_valid  (pt_valid),
        .pt_accept (pt_accept),
        .ct_in     (ct_in),
        .ct_valid  (ct_valid),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor state: counters only ever grow; the stimulus takes snapshots.
    int           tx_cnt = 0;
    int           tx_bad = 0;
    int           kv_cnt = 0;
    int           pv_cnt = 0;
    logic [7:0]   tx_last = 8'h00;
    logic [127:0] tx_shift = '0;
    logic         ready_at_edge = 1'b0;

    always @(posedge clk) ready_at_edge = tx_ready;

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_enable) begin
                tx_cnt   = tx_cnt + 1;
                tx_last  = tx_data;
                tx_shift = {tx_shift[119:0], tx_data};
                if (!ready_at_edge) tx_bad = tx_bad + 1;
                $display("tx byte %02h", tx_data);
            end
            if (key_valid) kv_cnt = kv_cnt + 1;
            if (pt_valid)  pv_cnt = pv_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        $display("rx byte %02h -> busy=%0b err=%0b", b, busy, err);
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int k = 0;
        while (busy !== 1'b0 && k < max_cyc) begin
            tick(1);
            k++;
        end
        chk(tag, {127'd0, busy}, 128'd0);
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_tx_data"},   {120'd0, tx_data}, 128'd0);
        chk({pfx, "_tx_enable"}, {127'd0, tx_enable}, 128'd0);
        chk({pfx, "_key_out"},   key_out, 128'd0);
        chk({pfx, "_key_valid"}, {127'd0, key_valid}, 128'd0);
        chk({pfx, "_pt_out"},    pt_out, 128'd0);
        chk({pfx, "_pt_valid"},  {127'd0, pt_valid}, 128'd0);
        chk({pfx, "_busy"},      {127'd0, busy}, 128'd0);
        chk({pfx, "_err"},       {127'd0, err}, 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int tx0;
        int kv0;
        int pv0;
        int k;
        logic [127:0] ct_vec;

        ct_vec = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

        // Reset state
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(1);

        // Key load 00..0F
        tx0 = tx_cnt;
        kv0 = kv_cnt;
        send_byte(8'h4B);
        chk("key_busy", {127'd0, busy}, 128'd1);
        for (int i = 0; i < 15; i++) send_byte(8'(i));
        chk("key_no_early_valid", {127'd0, key_valid}, 128'd0);
        send_byte(8'h0F);
        chk("key_out", key_out, 128'h000102030405060708090A0B0C0D0E0F);
        chk("key_valid_pulse", {127'd0, key_valid}, 128'd1);
        tick(1);
        chk("key_valid_drop", {127'd0, key_valid}, 128'd0);
        wait_idle("key_idle", 50);
        chk("key_valid_count", 128'(kv_cnt - kv0), 128'd1);
        chk("key_ack_count", 128'(tx_cnt - tx0), 128'd1);
        chk("key_ack_byte", {120'd0, tx_last}, 128'h4B);

        // Encrypt request with pt_accept delayed 5 cycles
        pv0 = pv_cnt;
        send_byte(8'h45);
        for (int i = 0; i < 16; i++) send_byte(8'hAA);
        chk("pt_out", pt_out, {16{8'hAA}});
        for (int i = 1; i <= 5; i++) begin
            chk("pt_valid_held", {127'd0, pt_valid}, 128'd1);
            ct_valid  = (i == 2);
            ct_in     = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
            pt_accept = (i == 5);
            tick(1);
        end
        pt_accept = 1'b0;
        ct_valid  = 1'b0;
        chk("pt_valid_drop", {127'd0, pt_valid}, 128'd0);
        chk("pt_valid_cycles", 128'(pv_cnt - pv0), 128'd5);
        chk("wait_ct_busy", {127'd0, busy}, 128'd1);
        chk("key_kept_by_enc", key_out, 128'h000102030405060708090A0B0C0D0E0F);
        tick(3);
        chk("ct_ignored_in_wait_core", 128'(tx_cnt - tx0), 128'd1);

        // Ciphertext serialisation with a byte dropped during TX_SEND
        tx0 = tx_cnt;
        tx_ready = 1'b0;
        ct_in    = ct_vec;
        ct_valid = 1'b1;
        tick(1);
        ct_valid = 1'b0;
        ct_in    = '0;
        send_byte(8'h77);
        chk("rx_in_tx_err", {127'd0, err}, 128'd1);
        chk("rx_in_tx_busy", {127'd0, busy}, 128'd1);
        chk("no_tx_while_not_ready", 128'(tx_cnt - tx0), 128'd0);
        k = 0;
        while (busy === 1'b1 && k < 400) begin
            tx_ready = ((k % 4) >= 2);
            tick(1);
            k++;
        end
        tx_ready = 1'b1;
        chk("ct_idle", {127'd0, busy}, 128'd0);
        chk("ct_tx_count", 128'(tx_cnt - tx0), 128'd16);
        chk("ct_tx_bytes", tx_shift, ct_vec);
        chk("ct_tx_only_when_ready", 128'(tx_bad), 128'd0);

        // Timeout with a byte landing exactly on the expiry cycle
        pv0 = pv_cnt;
        send_byte(8'h45);
        chk("enc_clears_err", {127'd0, err}, 128'd0);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i));
        tick(TMO - 1);
        send_byte(8'h16);
        chk("byte_beats_timeout_busy", {127'd0, busy}, 128'd1);
        chk("byte_beats_timeout_err", {127'd0, err}, 128'd0);
        tick(TMO - 1);
        chk("pre_timeout_busy", {127'd0, busy}, 128'd1);
        chk("pre_timeout_err", {127'd0, err}, 128'd0);
        tick(1);
        chk("timeout_idle", {127'd0, busy}, 128'd0);
        chk("timeout_err", {127'd0, err}, 128'd1);
        chk("timeout_no_pt_valid", 128'(pv_cnt - pv0), 128'd0);
        send_byte(8'h4B);
        chk("key_cmd_clears_err", {127'd0, err}, 128'd0);

        // Reset after the 10th key byte
        tx0 = tx_cnt;
        for (int i = 0; i < 10; i++) send_byte(8'(8'hC0 + i));
        rst = 1'b1;
        tick(1);
        check_all_zero("midrst");
        rst = 1'b0;
        tick(5);
        chk("midrst_no_tx", 128'(tx_cnt - tx0), 128'd0);

        // Full key load after reset
        kv0 = kv_cnt;
        send_byte(8'h4B);
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i));
        chk("key2_out", key_out, 128'h101112131415161718191A1B1C1D1E1F);
        wait_idle("key2_idle", 50);
        chk("key2_valid_count", 128'(kv_cnt - kv0), 128'd1);
        chk("key2_ack_count", 128'(tx_cnt - tx0), 128'd1);
        chk("key2_ack_byte", {120'd0, tx_last}, 128'h4B);

        // Unknown command in IDLE
        send_byte(8'h33);
        chk("bad_cmd_err", {127'd0, err}, 128'd1);
        chk("bad_cmd_busy", {127'd0, busy}, 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_aes_framer.md
UART_AES_FRAMER -- requirements
Module: uart_aes_framer

Interface
REQ-001 SHALL have parameter CMD_KEY, default 8'h4B, command byte that loads a 128-bit key.
REQ-002 SHALL have parameter CMD_ENC, default 8'h45, command byte that starts one block encryption.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1200000, maximum idle clk cycles allowed between payload bytes.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port rx_ready  in  1  one-cycle pulse per received UART byte.
REQ-007 SHALL have port rx_data  in  8  received byte; valid when rx_ready=1.
REQ-008 SHALL have port tx_ready  in  1  UART transmitter idle flag.
REQ-009 SHALL have port tx_data  out  8  byte to transmit; stable while tx_enable=1.
REQ-010 SHALL have port tx_enable  out  1  one-cycle transmit strobe.
REQ-011 SHALL have port key_out  out  128  loaded key, first received byte in [127:120].
REQ-012 SHALL have port key_valid  out  1  one-cycle pulse when key_out updates.
REQ-013 SHALL have port pt_out  out  128  plaintext block, first received byte in [127:120].
REQ-014 SHALL have port pt_valid  out  1  held high until core accepts.
REQ-015 SHALL have port pt_accept  in  1  core accepts plaintext when high with pt_valid.
REQ-016 SHALL have port ct_in  in  128  ciphertext from core.
REQ-017 SHALL have port ct_valid  in  1  one-cycle pulse qualifying ct_in.
REQ-018 SHALL have port busy  out  1  high in every state except IDLE.
REQ-019 SHALL have port err  out  1  sticky protocol error flag.

Function
REQ-020 SHALL implement FSM states IDLE, RX_KEY, RX_PT, WAIT_CORE, WAIT_CT, TX_SEND, TX_GAP.
REQ-021 SHALL, in IDLE, on rx_ready: CMD_KEY -> RX_KEY; CMD_ENC -> RX_PT; any other byte -> set err and stay in IDLE.
REQ-022 SHALL clear err on acceptance of a valid command byte.
REQ-023 SHALL shift each payload byte into a 128-bit register MSB-first, using a 4-bit byte counter that is cleared on state entry.
REQ-024 SHALL, in RX_KEY, on the 16th byte: copy the register to key_out, pulse key_valid in the next cycle, queue a single ack byte equal to CMD_KEY, and go to TX_SEND.
REQ-025 SHALL, in RX_PT, on the 16th byte: drive pt_out, assert pt_valid in the next cycle, and go to WAIT_CORE.
REQ-026 SHALL, in WAIT_CORE, deassert pt_valid and go to WAIT_CT in the cycle after pt_valid=1 and pt_accept=1.
REQ-027 SHALL, in WAIT_CT, on ct_valid: latch ct_in, queue 16 bytes MSB-first, and go to TX_SEND; ct_valid in any other state SHALL be ignored.
REQ-028 SHALL, in TX_SEND, wait for tx_ready=1, then pulse tx_enable for exactly one cycle with the current byte, and go to TX_GAP.
REQ-029 SHALL, in TX_GAP, ignore tx_ready for 2 cycles, then return to TX_SEND if bytes remain, else go to IDLE.
REQ-030 SHALL run a timeout counter in RX_KEY and RX_PT that is cleared by each rx_ready; on reaching TIMEOUT_CYCLES it SHALL discard the partial payload, set err, and go to IDLE.
REQ-031 SHALL give priority to a byte over the timeout when rx_ready coincides with expiry: the byte is accepted and the counter cleared.
REQ-032 SHALL drop any rx_ready byte received in WAIT_CORE, WAIT_CT, TX_SEND or TX_GAP and set err, leaving the state unchanged.
REQ-033 SHALL leave key_out unchanged by CMD_ENC transactions and by aborted key loads.
REQ-034 SHALL keep tx_enable, key_valid and pt_valid free of glitches, with at most one tx_enable per byte.

Reset
REQ-035 SHALL, on rst=1 at a clk edge, enter IDLE and clear all outputs to 0: tx_data, tx_enable, key_out, key_valid, pt_out, pt_valid, busy and err.
REQ-036 SHALL apply reset from any state mid-operation, abandoning partial payloads and pending transmissions without emitting a further tx_enable.

Verification
REQ-037 SHALL verify: 8'h4B followed by bytes 00..0F -> key_out=128'h000102030405060708090A0B0C0D0E0F, one key_valid pulse, one tx byte 8'h4B.
REQ-038 SHALL verify: 8'h45 followed by 16 bytes 8'hAA, pt_accept delayed 5 cycles -> pt_valid held for 5 cycles, pt_out all 8'hAA.
REQ-039 SHALL verify: ct_valid with ct_in=128'h69C4E0D86A7B0430D8CDB78070B4C55A -> 16 tx_enable pulses, bytes 69,C4,...,5A in order, each sent only while tx_ready=1.
REQ-040 SHALL verify: 8'h45, 7 bytes, then silence for TIMEOUT_CYCLES -> err=1, IDLE, no pt_valid; a following 8'h4B clears err.
REQ-041 SHALL verify: byte 8'h33 in IDLE -> err=1, busy=0; a byte received during TX_SEND -> err=1 with the transmit sequence intact.
REQ-042 SHALL verify: rst asserted after the 10th key byte -> all outputs 0 next cycle; a subsequent full key load succeeds.
